spram_boot_ctrl: RTL and testbench

SPRAM_BOOT_CTRL -- requirements
Module: spram_boot_ctrl

---
 rtl/spram_boot_pkg.sv | 17 +
 rtl/rd_valid_pipe.sv | 30 +++
 rtl/spram_boot_ctrl.sv | 149 ++++++++++++++
 tb/tb_spram_boot_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spram_boot_pkg.sv
// Shared types and default constants for the SPRAM boot controller.
// The controller loads a boot image into SPRAM, then hands the memory to the SoC.
package spram_boot_pkg;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_FILL,
    ST_HOLD,
    ST_RUN,
    ST_ERR
  } state_t;

  // Wide enough for any supported DW; users slice the low DW bits.
  localparam logic [1023:0] DEF_TERM_WORD = '1;
  localparam int            DEF_RST_DELAY = 4;

endpackage

// File: rtl/rd_valid_pipe.sv
// Read-valid delay line: soc_re_i delayed RD_LAT cycles.
// Loads only while the SoC owns the memory and clears as soon as it does not.
module rd_valid_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_run,
  input  logic i_re,
  output logic o_valid
);

  logic [RD_LAT-1:0] r_sr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sr <= '0;
    end else if (!i_run) begin
      r_sr <= '0;
    end else begin
      r_sr[0] <= i_re;
      for (int i = 1; i < RD_LAT; i++) begin
        r_sr[i] <= r_sr[i-1];
      end
    end
  end

  assign o_valid = r_sr[RD_LAT-1];

endmodule

// File: rtl/spram_boot_ctrl.sv
// SPRAM boot controller: streams a flash image into SPRAM, holds the SoC in
// reset for RST_DELAY cycles after the sentinel word, then passes SPRAM to the SoC.
module spram_boot_ctrl
  import spram_boot_pkg::*;
#(
  parameter int              AW        = 14,
  parameter int              DW        = 32,
  parameter int              MAX_WORDS = 16384,
  parameter logic [DW-1:0]   TERM_WORD = DEF_TERM_WORD[DW-1:0],
  parameter int              RST_DELAY = DEF_RST_DELAY,
  parameter int              RD_LAT    = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ip_done_i,
  input  logic              reload_i,
  output logic              ld_fill_o,
  input  logic              ld_valid_i,
  input  logic [DW-1:0]     ld_data_i,
  input  logic [AW-1:0]     soc_addr_i,
  input  logic [DW-1:0]     soc_din_i,
  input  logic              soc_we_i,
  input  logic [DW/8-1:0]   soc_maskwe_i,
  input  logic              soc_re_i,
  output logic [DW-1:0]     soc_dout_o,
  output logic              soc_read_valid_o,
  output logic              soc_rstn_o,
  output logic [AW-1:0]     mem_addr_o,
  output logic [DW-1:0]     mem_din_o,
  output logic              mem_we_o,
  output logic [DW/8-1:0]   mem_maskwe_o,
  input  logic [DW-1:0]     mem_dout_i,
  output logic              load_done_o,
  output logic              overflow_o,
  output logic [AW:0]       word_count_o
);

  localparam logic [AW:0] CNT_ONE    = (AW+1)'(1);
  localparam logic [AW:0] CNT_LAST   = (AW+1)'(MAX_WORDS - 1);
  localparam logic [7:0]  DELAY_LAST = 8'(RST_DELAY - 1);

  state_t      r_state;
  logic [AW:0] r_cnt;
  logic [7:0]  r_delay;
  logic        r_fill;
  logic        r_done;
  logic        r_rstn;
  logic        r_ovf;
  logic        w_reload_ok;
  logic        w_run;

  // A reload mid-FILL would corrupt a half-written image, so it only counts afterwards.
  assign w_reload_ok = reload_i &&
                       (r_state == ST_HOLD || r_state == ST_RUN || r_state == ST_ERR);
  assign w_run       = (r_state == ST_RUN);

  // NOTE: every register here uses <= so each one samples pre-edge values; a
  // blocking = would make later statements see this cycle's updated state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_WAIT;
      r_cnt   <= '0;
      r_delay <= '0;
      r_fill  <= 1'b0;
      r_done  <= 1'b0;
      r_rstn  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_reload_ok) begin
      r_state <= ST_FILL;
      r_cnt   <= '0;
      r_delay <= '0;
      r_fill  <= 1'b1;
      r_done  <= 1'b0;
      r_rstn  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (ip_done_i) begin
            r_state <= ST_FILL;
            r_fill  <= 1'b1;
          end
        end
        ST_FILL: begin
          if (ld_valid_i) begin
            r_cnt <= r_cnt + CNT_ONE;
            // Sentinel wins over the last-slot overflow check.
            if (ld_data_i == TERM_WORD) begin
              r_state <= ST_HOLD;
              r_fill  <= 1'b0;
              r_delay <= '0;
            end else if (r_cnt == CNT_LAST) begin
              r_state <= ST_ERR;
              r_fill  <= 1'b0;
              r_ovf   <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (r_delay == DELAY_LAST) begin
            r_state <= ST_RUN;
            r_rstn  <= 1'b1;
            r_done  <= 1'b1;
          end else begin
            r_delay <= r_delay + 8'd1;
          end
        end
        ST_RUN, ST_ERR: begin
        end
        default: r_state <= ST_WAIT;
      endcase
    end
  end

  // NOTE: every output gets a default before the branches so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    mem_addr_o   = soc_addr_i;
    mem_din_o    = soc_din_i;
    mem_maskwe_o = soc_maskwe_i;
    mem_we_o     = 1'b0;
    if (r_state == ST_FILL) begin
      mem_addr_o   = r_cnt[AW-1:0];
      mem_din_o    = ld_data_i;
      mem_maskwe_o = '1;
      mem_we_o     = ld_valid_i;
    end else if (w_run) begin
      mem_we_o = soc_we_i;
    end
  end

  rd_valid_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_valid_pipe (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_run   (w_run),
    .i_re    (soc_re_i),
    .o_valid (soc_read_valid_o)
  );

  assign soc_dout_o   = mem_dout_i;
  assign ld_fill_o    = r_fill;
  assign load_done_o  = r_done;
  assign soc_rstn_o   = r_rstn;
  assign overflow_o   = r_ovf;
  assign word_count_o = r_cnt;

endmodule

// File: tb/tb_spram_boot_ctrl.sv
// Self-checking bench for spram_boot_ctrl: every expected SPRAM write is queued
// when stimulus is driven and compared when mem_we_o appears.
module tb_spram_boot_ctrl;

  localparam int AW = 14;
  localparam int DW = 32;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [DW-1:0]   data;
    logic [DW/8-1:0] mask;
  } wr_t;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            ip_done_i;
  logic            reload_i;
  logic            ld_fill_o;
  logic            ld_valid_i;
  logic [DW-1:0]   ld_data_i;
  logic [AW-1:0]   soc_addr_i;
  logic [DW-1:0]   soc_din_i;
  logic            soc_we_i;
  logic [DW/8-1:0] soc_maskwe_i;
  logic            soc_re_i;
  logic [DW-1:0]   soc_dout_o;
  logic            soc_read_valid_o;
  logic            soc_rstn_o;
  logic [AW-1:0]   mem_addr_o;
  logic [DW-1:0]   mem_din_o;
  logic            mem_we_o;
  logic [DW/8-1:0] mem_maskwe_o;
  logic [DW-1:0]   mem_dout_i;
  logic            load_done_o;
  logic            overflow_o;
  logic [AW:0]     word_count_o;

  int  n_checks = 0;
  int  n_errors = 0;
  wr_t sb[$];

  always #5 clk_i = ~clk_i;

  spram_boot_ctrl #(
    .AW        (AW),
    .DW        (DW),
    .MAX_WORDS (8),
    .RST_DELAY (4),
    .RD_LAT    (2)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .ip_done_i        (ip_done_i),
    .reload_i         (reload_i),
    .ld_fill_o        (ld_fill_o),
    .ld_valid_i       (ld_valid_i),
    .ld_data_i        (ld_data_i),
    .soc_addr_i       (soc_addr_i),
    .soc_din_i        (soc_din_i),
    .soc_we_i         (soc_we_i),
    .soc_maskwe_i     (soc_maskwe_i),
    .soc_re_i         (soc_re_i),
    .soc_dout_o       (soc_dout_o),
    .soc_read_valid_o (soc_read_valid_o),
    .soc_rstn_o       (soc_rstn_o),
    .mem_addr_o       (mem_addr_o),
    .mem_din_o        (mem_din_o),
    .mem_we_o         (mem_we_o),
    .mem_maskwe_o     (mem_maskwe_o),
    .mem_dout_i       (mem_dout_i),
    .load_done_o      (load_done_o),
    .overflow_o       (overflow_o),
    .word_count_o     (word_count_o)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic ld_word(input logic [DW-1:0] d, input int a);
    ld_valid_i = 1'b1;
    ld_data_i  = d;
    sb.push_back({AW'(a), d, {(DW/8){1'b1}}});
    tick();
    ld_valid_i = 1'b0;
  endtask

  task automatic pulse_reload();
    reload_i = 1'b1;
    tick();
    reload_i = 1'b0;
  endtask

  // Write monitor: any write with nothing queued compares against X and fails.
  always @(negedge clk_i) begin
    if (mem_we_o === 1'b1) begin
      wr_t e;
      e = 'x;
      if (sb.size() > 0) e = sb.pop_front();
      check("wr_addr", 64'(mem_addr_o), 64'(e.addr));
      check("wr_data", 64'(mem_din_o), 64'(e.data));
      check("wr_mask", 64'(mem_maskwe_o), 64'(e.mask));
    end
  end

  initial begin
    rst_i = 1'b1; ip_done_i = 1'b0; reload_i = 1'b0;
    ld_valid_i = 1'b0; ld_data_i = '0;
    soc_addr_i = '0; soc_din_i = '0; soc_we_i = 1'b0; soc_maskwe_i = '0;
    soc_re_i = 1'b0; mem_dout_i = '0;

    // Reset values
    repeat (2) tick();
    check("rst_fill", ld_fill_o, 0);
    check("rst_done", load_done_o, 0);
    check("rst_rstn", soc_rstn_o, 0);
    check("rst_ovf", overflow_o, 0);
    check("rst_rvalid", soc_read_valid_o, 0);
    check("rst_we", mem_we_o, 0);
    check("rst_wc", word_count_o, 0);
    rst_i = 1'b0;
    repeat (2) tick();
    check("wait_idle_fill", ld_fill_o, 0);

    // (a) three-word image, sentinel last
    ip_done_i = 1'b1;
    tick();
    check("a_fill", ld_fill_o, 1);
    ld_word(32'h0000_0011, 0);
    tick();
    ld_word(32'h0000_0022, 1);
    ld_word(32'hFFFF_FFFF, 2);
    check("a_wc", word_count_o, 3);
    check("a_hold_fill", ld_fill_o, 0);
    check("a_hold_rstn0", soc_rstn_o, 0);
    ld_valid_i = 1'b1;
    ld_data_i  = 32'h5555_5555;
    repeat (3) tick();
    check("a_hold_rstn3", soc_rstn_o, 0);
    ld_valid_i = 1'b0;
    tick();
    check("a_run_rstn", soc_rstn_o, 1);
    check("a_run_done", load_done_o, 1);
    check("a_wc_hold", word_count_o, 3);

    // (c) SoC mirror and read-valid latency
    soc_addr_i = 14'd7; soc_din_i = 32'hA5A5_0001; soc_maskwe_i = 4'b0011; soc_we_i = 1'b1;
    sb.push_back({14'd7, 32'hA5A5_0001, 4'b0011});
    #1;
    check("c_mirror_addr", mem_addr_o, 7);
    check("c_mirror_we", mem_we_o, 1);
    tick();
    soc_we_i = 1'b0;
    mem_dout_i = 32'hCAFE_F00D;
    soc_re_i = 1'b1;
    #1;
    check("c_dout", soc_dout_o, 32'hCAFE_F00D);
    check("c_rv_t0", soc_read_valid_o, 0);
    tick();
    soc_re_i = 1'b0;
    check("c_rv_t1", soc_read_valid_o, 0);
    tick();
    check("c_rv_t2", soc_read_valid_o, 1);
    tick();
    check("c_rv_t3", soc_read_valid_o, 0);

    // (e) reload from RUN, with a read in flight that must be flushed
    soc_re_i = 1'b1;
    pulse_reload();
    soc_re_i = 1'b0;
    check("e_rstn", soc_rstn_o, 0);
    check("e_done", load_done_o, 0);
    check("e_fill", ld_fill_o, 1);
    check("e_wc", word_count_o, 0);
    tick();
    check("e_rv_flush", soc_read_valid_o, 0);

    // (d) SoC write during FILL is dropped; reload in FILL ignored
    soc_addr_i = 14'd5; soc_din_i = 32'h0000_0BAD; soc_maskwe_i = 4'b1111; soc_we_i = 1'b1;
    reload_i = 1'b1;
    #1;
    check("d_soc_we_drop", mem_we_o, 0);
    check("d_addr_loader", mem_addr_o, 0);
    tick();
    reload_i = 1'b0;
    check("d_reload_ign_fill", ld_fill_o, 1);
    check("d_reload_ign_wc", word_count_o, 0);
    ld_word(32'h0000_0033, 0);
    reload_i = 1'b1;
    ld_word(32'hFFFF_FFFF, 1);
    reload_i = 1'b0;
    soc_we_i = 1'b0;
    check("e_term_reload_fill", ld_fill_o, 0);
    check("e_term_reload_wc", word_count_o, 2);
    repeat (4) tick();
    check("e_run_rstn", soc_rstn_o, 1);

    // (b) overflow at MAX_WORDS=8, then recovery
    pulse_reload();
    check("b_fill", ld_fill_o, 1);
    for (int i = 0; i < 8; i++) ld_word(32'h100 + i, i);
    check("b_ovf", overflow_o, 1);
    check("b_fill_off", ld_fill_o, 0);
    check("b_rstn", soc_rstn_o, 0);
    check("b_done", load_done_o, 0);
    check("b_wc", word_count_o, 8);
    ld_valid_i = 1'b1;
    ld_data_i  = 32'hFFFF_FFFF;
    repeat (3) tick();
    ld_valid_i = 1'b0;
    check("b_err_sticky", overflow_o, 1);
    check("b_err_wc", word_count_o, 8);
    check("b_err_rstn", soc_rstn_o, 0);
    pulse_reload();
    check("b_reload_fill", ld_fill_o, 1);
    check("b_reload_ovf", overflow_o, 0);
    check("b_reload_wc", word_count_o, 0);

    // Sentinel in the last slot wins over overflow
    for (int i = 0; i < 7; i++) ld_word(32'h200 + i, i);
    ld_word(32'hFFFF_FFFF, 7);
    check("last_ovf", overflow_o, 0);
    check("last_fill", ld_fill_o, 0);
    check("last_wc", word_count_o, 8);
    repeat (4) tick();
    check("last_rstn", soc_rstn_o, 1);

    // (f) reset mid-FILL, then reload from address 0
    pulse_reload();
    ld_word(32'h0000_0044, 0);
    ld_word(32'h0000_0055, 1);
    check("f_wc2", word_count_o, 2);
    #2;
    rst_i = 1'b1;
    ld_valid_i = 1'b1;
    ld_data_i = 32'h0000_0066;
    #1;
    check("f_rst_fill", ld_fill_o, 0);
    check("f_rst_done", load_done_o, 0);
    check("f_rst_rstn", soc_rstn_o, 0);
    check("f_rst_ovf", overflow_o, 0);
    check("f_rst_rvalid", soc_read_valid_o, 0);
    check("f_rst_we", mem_we_o, 0);
    check("f_rst_wc", word_count_o, 0);
    repeat (2) tick();
    ld_valid_i = 1'b0;
    rst_i = 1'b0;
    tick();
    check("f_refill", ld_fill_o, 1);
    check("f_refill_wc", word_count_o, 0);
    ld_word(32'h0000_0077, 0);
    check("f_wc1", word_count_o, 1);

    tick();
    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
